// File: rtl/pipeline_stage4_mem_wb.sv
// Memory/writeback stage: runs the data-memory req/ack access for loads and stores,
// stalls upstream while it waits, then drives the register-file write port.
module pipeline_stage4_mem_wb #(
   parameter int ACK_TIMEOUT = 15,
   parameter int DW          = 16,
   parameter int AW          = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_in,
   input  logic          reg_we_in,
   input  logic          mem_bypass_in,
   input  logic          mem_we_in,
   input  logic          aux_in,
   input  logic [AW-1:0] wa_in,
   input  logic [DW-1:0] alu_in,
   input  logic [DW-1:0] sd_in,
   output logic          stall_out,
   output logic          mem_req,
   output logic          mem_wr,
   output logic [DW-2:0] mem_addr,
   output logic [1:0]    mem_be,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic          rf_we,
   output logic [AW-1:0] rf_wa,
   output logic [DW-1:0] rf_wd,
   output logic          err
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   localparam int              CW       = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
   localparam logic [CW-1:0]   CNT_LAST = CW'(ACK_TIMEOUT - 1);

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_wr_q, mem_wr_d;
   logic [DW-2:0] mem_addr_q, mem_addr_d;
   logic [1:0]    mem_be_q, mem_be_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [AW-1:0] wa_q, wa_d;
   logic          ldwe_q, ldwe_d;
   logic          aux_q, aux_d;
   logic          a0_q, a0_d;
   logic          rf_we_q, rf_we_d;
   logic [AW-1:0] rf_wa_q, rf_wa_d;
   logic [DW-1:0] rf_wd_q, rf_wd_d;
   logic          sk_vld_q, sk_vld_d;
   logic [AW-1:0] sk_wa_q, sk_wa_d;
   logic [DW-1:0] sk_wd_q, sk_wd_d;

   logic in_wait, ack_w, tmo_w, free_w, accept_w, mem_acc_w, alu_wr_w, ld_wr_w;

   function automatic logic [DW-1:0] load_data(input logic byte_acc, input logic hi,
                                                input logic [DW-1:0] rd);
      if (!byte_acc) return rd;
      return {{(DW-8){1'b0}}, (hi ? rd[15:8] : rd[7:0])};
   endfunction

   assign in_wait   = (state_q == S_WAIT);
   assign ack_w     = in_wait && mem_ack;
   assign tmo_w     = in_wait && !mem_ack && (cnt_q == CNT_LAST);
   assign free_w    = !in_wait || ack_w || tmo_w;
   assign stall_out = !free_w;
   assign accept_w  = free_w && valid_in;
   assign mem_acc_w = mem_we_in || !mem_bypass_in;
   assign alu_wr_w  = accept_w && !mem_acc_w && reg_we_in && (wa_in != '0);
   assign ld_wr_w   = ack_w && ldwe_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q || tmo_w;
      mem_req_d   = mem_req_q;
      mem_wr_d    = mem_wr_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      wa_d        = wa_q;
      ldwe_d      = ldwe_q;
      aux_d       = aux_q;
      a0_d        = a0_q;
      if (ack_w || tmo_w) begin
         state_d   = S_IDLE;
         mem_req_d = 1'b0;
      end else if (in_wait) begin
         cnt_d = cnt_q + CW'(1);
      end
      // A new access may start on the same edge that retires the previous one
      if (accept_w && mem_acc_w) begin
         state_d     = S_WAIT;
         cnt_d       = '0;
         mem_req_d   = 1'b1;
         mem_wr_d    = mem_we_in;
         mem_addr_d  = alu_in[DW-1:1];
         mem_be_d    = aux_in ? (alu_in[0] ? 2'b10 : 2'b01) : 2'b11;
         mem_wdata_d = aux_in ? {(DW/8){sd_in[7:0]}} : sd_in;
         wa_d        = wa_in;
         ldwe_d      = reg_we_in && !mem_we_in && (wa_in != '0);
         aux_d       = aux_in;
         a0_d        = alu_in[0];
      end
   end

   // A load completing on the same edge as an ALU op takes the port first; the ALU
   // result rides a one-entry skid so both retire on consecutive cycles.
   always_comb begin
      rf_we_d  = 1'b0;
      rf_wa_d  = rf_wa_q;
      rf_wd_d  = rf_wd_q;
      sk_vld_d = 1'b0;
      sk_wa_d  = sk_wa_q;
      sk_wd_d  = sk_wd_q;
      if (ld_wr_w || sk_vld_q) begin
         rf_we_d = 1'b1;
         rf_wa_d = ld_wr_w ? wa_q : sk_wa_q;
         rf_wd_d = ld_wr_w ? load_data(aux_q, a0_q, mem_rdata) : sk_wd_q;
         if (alu_wr_w) begin
            sk_vld_d = 1'b1;
            sk_wa_d  = wa_in;
            sk_wd_d  = alu_in;
         end
      end else if (alu_wr_w) begin
         rf_we_d = 1'b1;
         rf_wa_d = wa_in;
         rf_wd_d = alu_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         wa_q        <= '0;
         ldwe_q      <= 1'b0;
         aux_q       <= 1'b0;
         a0_q        <= 1'b0;
         rf_we_q     <= 1'b0;
         rf_wa_q     <= '0;
         rf_wd_q     <= '0;
         sk_vld_q    <= 1'b0;
         sk_wa_q     <= '0;
         sk_wd_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         mem_req_q   <= mem_req_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         wa_q        <= wa_d;
         ldwe_q      <= ldwe_d;
         aux_q       <= aux_d;
         a0_q        <= a0_d;
         rf_we_q     <= rf_we_d;
         rf_wa_q     <= rf_wa_d;
         rf_wd_q     <= rf_wd_d;
         sk_vld_q    <= sk_vld_d;
         sk_wa_q     <= sk_wa_d;
         sk_wd_q     <= sk_wd_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign rf_we     = rf_we_q;
   assign rf_wa     = rf_wa_q;
   assign rf_wd     = rf_wd_q;
   assign err       = err_q;

endmodule

// File: tb/tb_pipeline_stage4_mem_wb.sv
// Directed bench for pipeline_stage4_mem_wb: ALU writeback table plus hand-written
// load/store, back-to-back, timeout and reset-mid-access sequences.
module tb_pipeline_stage4_mem_wb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_in = 1'b0, reg_we_in = 1'b0, mem_bypass_in = 1'b1;
   logic        mem_we_in = 1'b0, aux_in = 1'b0;
   logic [4:0]  wa_in = '0;
   logic [15:0] alu_in = '0, sd_in = '0;
   logic        stall_out, mem_req, mem_wr;
   logic [14:0] mem_addr;
   logic [1:0]  mem_be;
   logic [15:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [15:0] rf_wd;
   logic        err;

   int errors = 0;
   int checks = 0;

   pipeline_stage4_mem_wb #(.ACK_TIMEOUT(4), .DW(16), .AW(5)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .reg_we_in(reg_we_in),
      .mem_bypass_in(mem_bypass_in), .mem_we_in(mem_we_in), .aux_in(aux_in),
      .wa_in(wa_in), .alu_in(alu_in), .sd_in(sd_in), .stall_out(stall_out),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic        we;
      logic [4:0]  wa;
      logic [15:0] alu;
      logic        exp_we;
      logic [4:0]  exp_wa;
      logic [15:0] exp_wd;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic we, input logic byp, input logic mwe,
                        input logic aux, input logic [4:0] wa, input logic [15:0] alu,
                        input logic [15:0] sd);
      valid_in = vld; reg_we_in = we; mem_bypass_in = byp; mem_we_in = mwe;
      aux_in = aux; wa_in = wa; alu_in = alu; sd_in = sd;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b1, 5'd3,  16'h1234, 1'b1, 5'd3,  16'h1234};
      vecs[1] = '{1'b1, 1'b0, 5'd4,  16'h5555, 1'b0, 5'd0,  16'h0};
      vecs[2] = '{1'b1, 1'b1, 5'd0,  16'h7777, 1'b0, 5'd0,  16'h0};
      vecs[3] = '{1'b0, 1'b1, 5'd6,  16'h8888, 1'b0, 5'd0,  16'h0};
      vecs[4] = '{1'b1, 1'b1, 5'd31, 16'hFFFF, 1'b1, 5'd31, 16'hFFFF};
      vecs[5] = '{1'b1, 1'b1, 5'd1,  16'h0001, 1'b1, 5'd1,  16'h0001};

      // Reset state
      #2;
      chk("rst_rf_we", rf_we, 0);       chk("rst_rf_wa", rf_wa, 0);
      chk("rst_rf_wd", rf_wd, 0);       chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_wr", mem_wr, 0);     chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_be", mem_be, 0);     chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_err", err, 0);           chk("rst_stall", stall_out, 0);
      step();
      rst = 1'b0;
      step();

      // ALU writeback table; a row expecting rf_we=0 also proves the previous pulse lasted one cycle
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].vld, vecs[i].we, 1'b1, 1'b0, 1'b0, vecs[i].wa, vecs[i].alu, 16'h0);
         step();
         chk($sformatf("vec%0d_rf_we", i), rf_we, vecs[i].exp_we);
         if (vecs[i].exp_we) begin
            chk($sformatf("vec%0d_rf_wa", i), rf_wa, vecs[i].exp_wa);
            chk($sformatf("vec%0d_rf_wd", i), rf_wd, vecs[i].exp_wd);
         end
      end
      idle();
      step();
      chk("alu_pulse_end", rf_we, 0);

      // Word load, ack after three stalled cycles
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 16'h0040, 16'h0);
      step();
      idle();
      chk("wl_req", mem_req, 1);   chk("wl_wr", mem_wr, 0);
      chk("wl_addr", mem_addr, 15'h0020);   chk("wl_be", mem_be, 2'b11);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("wl_stall%0d", i), stall_out, 1);
         chk($sformatf("wl_norf%0d", i), rf_we, 0);
         step();
      end
      mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      #1;
      chk("wl_stall_ack", stall_out, 0);
      step();
      mem_ack = 1'b0; mem_rdata = 16'h0;
      chk("wl_rf_we", rf_we, 1);   chk("wl_rf_wa", rf_wa, 7);
      chk("wl_rf_wd", rf_wd, 16'hBEEF);   chk("wl_req_drop", mem_req, 0);
      chk("wl_no_err", err, 0);
      step();
      chk("wl_pulse_end", rf_we, 0);

      // Byte load from the high lane
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 16'h0041, 16'h0);
      step();
      idle();
      chk("bl_addr", mem_addr, 15'h0020);   chk("bl_be", mem_be, 2'b10);
      mem_ack = 1'b1; mem_rdata = 16'hA55A;
      step();
      mem_ack = 1'b0;
      chk("bl_rf_we", rf_we, 1);   chk("bl_rf_wa", rf_wa, 8);
      chk("bl_rf_wd", rf_wd, 16'h00A5);
      step();

      // Byte store with reg_we set: must never write the register file
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 16'h0040, 16'h00C3);
      step();
      idle();
      chk("bs_req", mem_req, 1);   chk("bs_wr", mem_wr, 1);
      chk("bs_addr", mem_addr, 15'h0020);   chk("bs_be", mem_be, 2'b01);
      chk("bs_wdata", mem_wdata, 16'hC3C3);
      step();
      chk("bs_norf_wait", rf_we, 0);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("bs_norf_ack", rf_we, 0);   chk("bs_req_drop", mem_req, 0);
      step();
      chk("bs_norf_after", rf_we, 0);

      // Back-to-back: load acked in its first wait cycle, ALU op presented on that cycle
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 16'h0002, 16'h0);
      step();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 16'h1111, 16'h0);
      mem_ack = 1'b1; mem_rdata = 16'h2222;
      #1;
      chk("b2b_stall", stall_out, 0);
      step();
      idle();
      mem_ack = 1'b0;
      chk("b2b_ld_we", rf_we, 1);   chk("b2b_ld_wa", rf_wa, 5);
      chk("b2b_ld_wd", rf_wd, 16'h2222);
      step();
      chk("b2b_alu_we", rf_we, 1);   chk("b2b_alu_wa", rf_wa, 6);
      chk("b2b_alu_wd", rf_wd, 16'h1111);
      step();
      chk("b2b_end", rf_we, 0);

      // Load to r0 is suppressed
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0004, 16'h0);
      step();
      idle();
      mem_ack = 1'b1; mem_rdata = 16'h4321;
      step();
      mem_ack = 1'b0;
      chk("r0_load_we", rf_we, 0);
      step();

      // Timeout after four wait cycles; ALU op presented on the timeout cycle
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 16'h0010, 16'h0);
      step();
      idle();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 16'hABCD, 16'h0);
         #1;
         chk($sformatf("to_req%0d", i), mem_req, 1);
         chk($sformatf("to_stall%0d", i), stall_out, (i < 3) ? 1 : 0);
         chk($sformatf("to_norf%0d", i), rf_we, 0);
         step();
      end
      idle();
      chk("to_req_drop", mem_req, 0);   chk("to_err", err, 1);
      chk("to_alu_we", rf_we, 1);   chk("to_alu_wa", rf_wa, 10);
      chk("to_alu_wd", rf_wd, 16'hABCD);
      step();
      chk("to_err_sticky", err, 1);   chk("to_pulse_end", rf_we, 0);

      // Reset two cycles into the wait
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 16'h0020, 16'h0);
      step();
      idle();
      step();
      step();
      chk("rw_req_before", mem_req, 1);
      rst = 1'b1;
      #1;
      chk("rw_req_drop", mem_req, 0);   chk("rw_err_clr", err, 0);
      chk("rw_rf_we", rf_we, 0);
      step();
      rst = 1'b0;
      mem_ack = 1'b1; mem_rdata = 16'h9999;
      #1;
      chk("rw_idle_stall", stall_out, 0);
      step();
      mem_ack = 1'b0;
      chk("rw_ack_ignored", rf_we, 0);   chk("rw_req_idle", mem_req, 0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 16'h5A5A, 16'h0);
      step();
      idle();
      chk("rw_alu_we", rf_we, 1);   chk("rw_alu_wa", rf_wa, 12);
      chk("rw_alu_wd", rf_wd, 16'h5A5A);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
